dual_port_memory: RTL
=====================

DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL have parameter MMIO_BASE, default 32'h8000_0000, meaning region base address.
REQ-002 SHALL have parameter MMIO_MASK, default 32'hFFFF_F000, meaning region decode mask; depth in words = ((~MMIO_MASK)>>2)+1.
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted request to response; legal 1..4.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port d_req, input, 1, meaning data-port request strobe.
REQ-007 SHALL have port d_we, input, 1, meaning 1 = write, 0 = read.
REQ-008 SHALL have port d_be, input, 4, meaning byte-lane write enables; bit n covers bits 8n+7:8n.
REQ-009 SHALL have port d_addr, input, 32, meaning data-port byte address.
REQ-010 SHALL have port d_wdata, input, 32, meaning write data.
REQ-011 SHALL have port d_sel, output, 1, meaning combinational: (d_addr & MMIO_MASK) == MMIO_BASE.
REQ-012 SHALL have port d_rvalid, output, 1, meaning one-cycle response pulse for an accepted data request.
REQ-013 SHALL have port d_rdata, output, 32, meaning read data, valid only with d_rvalid.
REQ-014 SHALL have port d_err, output, 1, meaning misaligned-access flag, valid only with d_rvalid.
REQ-015 SHALL have port i_req, input, 1, meaning fetch request strobe.
REQ-016 SHALL have port i_addr, input, 32, meaning fetch byte address (pc).
REQ-017 SHALL have port i_rvalid, output, 1, meaning one-cycle fetch response pulse.
REQ-018 SHALL have port i_rdata, output, 32, meaning instruction word, valid only with i_rvalid.
REQ-019 SHALL have port i_err, output, 1, meaning misaligned-fetch flag, valid only with i_rvalid.

Function
REQ-020 A data request SHALL be accepted when d_req=1 and d_sel=1; a fetch SHALL be accepted when i_req=1 and the i_addr decode matches; unmatched requests SHALL be ignored and produce no response.
REQ-021 Both ports SHALL accept one request per cycle with no back-pressure; responses SHALL appear exactly READ_LATENCY cycles after acceptance, in order, through a READ_LATENCY-deep valid/data/err pipeline per port.
REQ-022 Word index SHALL be (addr & ~MMIO_MASK)>>2; higher address bits SHALL NOT affect indexing.
REQ-023 An access with addr[1:0] != 0 SHALL be misaligned: memory SHALL NOT be written, the response SHALL carry err=1 and rdata=0.
REQ-024 An aligned write SHALL update only the lanes enabled by d_be at the accepting edge; d_be=0 SHALL write nothing; the response SHALL carry rdata=0 and err=0.
REQ-025 An aligned read SHALL return the word as stored before the accepting edge's write (read-before-write), for both ports.
REQ-026 A data write and a fetch to the same word in the same cycle SHALL return the old word to the fetch; any later accepted access SHALL see the new word.
REQ-027 A data read following a write to the same word in the next cycle SHALL return the merged new word.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-029 While rst=1, d_rvalid, d_err, i_rvalid, i_err SHALL be 0, d_rdata and i_rdata SHALL be 0, and all pipeline valid stages SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight responses; no response pulse for a request accepted before reset SHALL appear after reset release.
REQ-031 Requests presented while rst=1 SHALL be ignored; the first request SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-032 Write 32'hDEADBEEF, d_be=4'hF, to 32'h8000_0010, then read it -> d_rvalid after READ_LATENCY, d_rdata=32'hDEADBEEF, d_err=0.
REQ-033 Word 32'h8000_0020 holds 32'h11223344; write 32'hAABBCCDD with d_be=4'b0101 -> subsequent read returns 32'h11BB33DD.
REQ-034 Read 32'h8000_0012 -> d_err=1, d_rdata=0; preceding stored value unchanged; write there also sets d_err=1 and modifies nothing.
REQ-035 Same cycle: write 32'h12345678 to 32'h8000_0040 (old 32'h0) and fetch i_addr=32'h8000_0040 -> i_rdata=32'h0; fetch in next cycle -> 32'h12345678.
REQ-036 READ_LATENCY=3, issue reads on 4 consecutive cycles, assert rst on cycle 2 for one cycle -> no d_rvalid pulses for those reads after release; a new read after release responds 3 cycles later.
REQ-037 d_req with d_addr=32'h9000_0000 -> d_sel=0, no d_rvalid, memory unchanged.

Source files
------------

// File: rtl/dual_port_memory.sv
// Dual-port word memory behind an MMIO decode window: a byte-enabled data port and
// a read-only fetch port, each returning responses through a fixed-latency pipeline.
module dual_port_memory #(
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter logic [31:0] MMIO_MASK    = 32'hFFFF_F000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_sel,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err
);

    localparam logic [31:0] OFFS_MASK = ~MMIO_MASK;
    localparam int          DEPTH     = int'(OFFS_MASK >> 2) + 1;
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    logic          i_sel;
    logic          d_acc;
    logic          i_acc;
    logic          d_mis;
    logic          i_mis;
    logic          d_wr_en;
    logic [AW-1:0] d_idx;
    logic [AW-1:0] i_idx;

    logic [READ_LATENCY-1:0] d_vld;
    logic [READ_LATENCY-1:0] d_er;
    logic [31:0]             d_dat [READ_LATENCY];
    logic [READ_LATENCY-1:0] i_vld;
    logic [READ_LATENCY-1:0] i_er;
    logic [31:0]             i_dat [READ_LATENCY];

    assign d_sel   = (d_addr & MMIO_MASK) == MMIO_BASE;
    assign i_sel   = (i_addr & MMIO_MASK) == MMIO_BASE;
    assign d_acc   = d_req && d_sel;
    assign i_acc   = i_req && i_sel;
    assign d_mis   = d_addr[1:0] != 2'b00;
    assign i_mis   = i_addr[1:0] != 2'b00;
    assign d_idx   = AW'((d_addr & OFFS_MASK) >> 2);
    assign i_idx   = AW'((i_addr & OFFS_MASK) >> 2);
    assign d_wr_en = d_acc && d_we && !d_mis && !rst;

    // No reset on the array: contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (d_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 samples mem before this edge's write lands, giving read-before-write on both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vld <= '0;
            d_er  <= '0;
            i_vld <= '0;
            i_er  <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                d_dat[s] <= '0;
                i_dat[s] <= '0;
            end
        end else begin
            d_vld[0] <= d_acc;
            d_er[0]  <= d_acc && d_mis;
            d_dat[0] <= (d_acc && !d_we && !d_mis) ? mem[d_idx] : 32'h0;
            i_vld[0] <= i_acc;
            i_er[0]  <= i_acc && i_mis;
            i_dat[0] <= (i_acc && !i_mis) ? mem[i_idx] : 32'h0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                d_vld[s] <= d_vld[s-1];
                d_er[s]  <= d_er[s-1];
                d_dat[s] <= d_dat[s-1];
                i_vld[s] <= i_vld[s-1];
                i_er[s]  <= i_er[s-1];
                i_dat[s] <= i_dat[s-1];
            end
        end
    end

    assign d_rvalid = d_vld[READ_LATENCY-1];
    assign d_err    = d_er[READ_LATENCY-1];
    assign d_rdata  = d_dat[READ_LATENCY-1];
    assign i_rvalid = i_vld[READ_LATENCY-1];
    assign i_err    = i_er[READ_LATENCY-1];
    assign i_rdata  = i_dat[READ_LATENCY-1];

endmodule
